ycio_bridge: RTL and testbench
==============================

// Module: ycio_bridge
// PURPOSE
//  Clocked-to-asynchronous bridge that feeds the top edge of a column of
//  yellow cells, acting as their "red cell". Encodes clocked words into
//  dual-rail values on uin and returns every lane to empty between words.
//  Synchronises the final results coming back on uout and hands them to
//  clocked logic through a valid/ready pair.
// PARAMETERS
//  WIDTH      8     number of array lanes (one yellow-cell column per lane)
//  SETTLE     2     consecutive identical synced samples needed to accept a result
//  TMO_CYCLES 1023  cycles in DRIVE/RELEASE before timeout (RCIO_TIMEOUT_EN only)
// PORTS
//  clk       in   1        system clock; the only clock
//  reset     in   1        synchronous, active-high; also sent to array reset
//  in_valid  in   1        in_data/in_drv hold a word to inject
//  in_ready  out  1        word accepted on clk edge where in_valid&in_ready
//  in_data   in   WIDTH    bit value per lane
//  in_drv    in   WIDTH    1 = drive lane with in_data, 0 = leave lane empty
//  res_mask  in   WIDTH    lanes whose uout returns a result; static per word
//  out_valid out  1        out_data holds a completed result
//  out_ready in   1        consumer takes result
//  out_data  out  WIDTH    1 where lane returned V1; 0 for V0 or unmasked
//  out_err   out  1        sticky: illegal 2'b11 seen on a masked lane
//  out_tmo   out  1        result ended by timeout (0 when macro off)
//  arr_uin   out  2*WIDTH  to cell uin pairs; lane i = [2i+1:2i]
//  arr_uout  in   2*WIDTH  from cell uout pairs; asynchronous
// BEHAVIOUR
//  Encoding per lane: 00 empty, 01 V0, 10 V1, 11 illegal.
//  arr_uout synced through 2 flops per wire; all decisions use synced copy.
//  arr_uin driven straight from flops; a lane changes only empty<->value, no
//   direct V0<->V1 transitions.
//  Reset values: arr_uin=0, in_ready=0, out_valid=0, out_data=0,
//   out_err=0, out_tmo=0, state=IDLE; sync flops cleared.
//  States:
//   IDLE: in_ready=1 only if every masked synced lane is empty.
//    Accept -> arr_uin latched next edge (lane = in_drv ? {d,~d} : 00),
//    res_mask captured, go DRIVE.
//   DRIVE: done when every captured-mask lane is non-empty and identical
//    across SETTLE consecutive samples -> out_data loaded, out_valid=1,
//    go HOLD. Masked lane = 11 -> out_err set, treated as non-empty.
//   HOLD: arr_uin kept; out_valid held stable until out_ready;
//    on handshake -> out_valid=0, arr_uin=0 same edge, go RELEASE.
//   RELEASE: wait until all masked lanes are empty for SETTLE samples -> IDLE.
//  Minimum latency: accept to out_valid = 1 (drive) + array delay + 2 (sync)
//   + SETTLE cycles. Throughput: one word per full four-phase cycle.
//  Empty mask (res_mask=0): DRIVE completes after SETTLE cycles, out_data=0.
//  in_valid while not IDLE: ignored, in_ready=0.
//  Reset in any state: all outputs return to reset values at that edge;
//   array sees empty inputs plus reset and clears its latches.
//  out_err clears only on reset.
// CONFIGURATION
//  RCIO_TIMEOUT_EN defined: counter runs in DRIVE and RELEASE and restarts
//   on every state entry. Reaching TMO_CYCLES in DRIVE -> out_valid=1,
//   out_tmo=1, out_data = lanes already V1, go HOLD. Reaching TMO_CYCLES in
//   RELEASE -> IDLE with out_tmo=1 until next accept.
//  RCIO_TIMEOUT_EN undefined: no counter, out_tmo tied 0; a stuck array
//   leaves the bridge in DRIVE or RELEASE until reset.
// TESTING
//  Behavioural array model echoing arr_uin to arr_uout after 3 clk delay,
//   in_data=8'hA5, in_drv=8'hFF, res_mask=8'hFF -> out_data=8'hA5,
//   out_valid at cycle accept+1+3+2+2, out_err=0.
//  Same model, out_ready held low 10 cycles -> out_valid and out_data stable;
//   arr_uin stays non-empty until handshake, then all lanes 00.
//  Model forces lane 3 to 11 -> out_err=1 stays set after later clean
//   words; cleared only by reset.
//  Reset asserted in DRIVE -> next edge arr_uin=0, out_valid=0, in_ready=0;
//   first word after release completes normally.
//  Model glitches lane 0 01->00->01 within SETTLE window -> no early
//   out_valid; result is taken only after 2 stable samples.
//  RCIO_TIMEOUT_EN, TMO_CYCLES=16, model never answers -> out_valid with
//   out_tmo=1 at 16 cycles after DRIVE entry; without macro no out_valid
//   after 1000 cycles.

Source files
------------

// File: rtl/ycio_if.sv
// ycio_if: clocked word/result handshake plus dual-rail array pins.
// slave = bridge side, master = clocked client / array side.
interface ycio_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [WIDTH-1:0]   in_drv;
    logic [WIDTH-1:0]   res_mask;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_err;
    logic               out_tmo;
    logic [2*WIDTH-1:0] arr_uin;
    logic [2*WIDTH-1:0] arr_uout;

    modport master (
        output in_valid, in_data, in_drv, res_mask,
        output out_ready, arr_uout,
        input  in_ready, out_valid, out_data,
        input  out_err, out_tmo, arr_uin
    );

    modport slave (
        input  in_valid, in_data, in_drv, res_mask,
        input  out_ready, arr_uout,
        output in_ready, out_valid, out_data,
        output out_err, out_tmo, arr_uin
    );
endinterface

// File: rtl/ycio_bridge.sv
// ycio_bridge: clocked-to-dual-rail "red cell" for a yellow-cell column.
// Optional DRIVE/RELEASE timeout enabled by defining RCIO_TIMEOUT_EN.
module ycio_bridge #(
    parameter int WIDTH      = 8,
    parameter int SETTLE     = 2,
    parameter int TMO_CYCLES = 1023
) (
    input  logic  clk,
    input  logic  reset,
    ycio_if.slave bus
);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD,
        RELEASE
    } state_t;

    state_t state, state_nx;

    logic [2*WIDTH-1:0] s1, s2, m, prev_q;
    logic [2*WIDTH-1:0] arr_q, word_q, word_nx;
    logic [2*WIDTH-1:0] mask2, req2;
    logic [WIDTH-1:0]   mask_q, v1, data_q;
    logic [CW-1:0]      cnt_q;
    logic full, ill, empty, clean, cond, same;
    logic settled, tmo_hit, accept;
    logic valid_q, err_q, tmo_q;

    always_comb begin
        mask2   = '0;
        req2    = '0;
        word_nx = '0;
        v1      = '0;
        full    = 1'b1;
        ill     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            mask2[2*i +: 2] = {2{mask_q[i]}};
            req2[2*i +: 2]  = {2{bus.res_mask[i]}};
            if (bus.in_drv[i])
                word_nx[2*i +: 2] = {bus.in_data[i], ~bus.in_data[i]};
        end
        m = s2 & mask2;
        // 11 counts as non-empty so a faulty lane cannot stall completion
        for (int i = 0; i < WIDTH; i++) begin
            v1[i] = (m[2*i +: 2] == 2'b10);
            if (mask_q[i] && m[2*i +: 2] == 2'b00)
                full = 1'b0;
            if (m[2*i +: 2] == 2'b11)
                ill = 1'b1;
        end
    end

    assign empty   = (m == '0);
    assign clean   = ((s2 & req2) == '0);
    assign accept  = bus.in_valid && bus.in_ready;
    assign cond    = (state == DRIVE) ? full : empty;
    assign same    = (cnt_q == '0) || (m == prev_q);
    assign settled = cond && same && (int'(cnt_q) + 1 >= SETTLE);

`ifdef RCIO_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == DRIVE || state == RELEASE)
                  && tmo_cnt == TW'(TMO_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset || state_nx != state)
            tmo_cnt <= '0;
        else if (state == DRIVE || state == RELEASE)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = DRIVE;
            DRIVE:   if (settled || tmo_hit) state_nx = HOLD;
            HOLD:    if (bus.out_ready) state_nx = RELEASE;
            RELEASE: if (settled || tmo_hit) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            s1      <= '0;
            s2      <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            arr_q   <= '0;
            word_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            s1     <= bus.arr_uout;
            s2     <= s1;
            prev_q <= m;
            // run length of identical qualifying samples
            if (state_nx != state)
                cnt_q <= '0;
            else if (cond && same) begin
                if (int'(cnt_q) < SETTLE)
                    cnt_q <= cnt_q + 1'b1;
            end else if (cond)
                cnt_q <= CW'(1);
            else
                cnt_q <= '0;
            if (accept) begin
                word_q <= word_nx;
                mask_q <= bus.res_mask;
                tmo_q  <= 1'b0;
            end
            if (state == DRIVE) begin
                arr_q <= word_q;
                if (ill)
                    err_q <= 1'b1;
                if (settled || tmo_hit) begin
                    valid_q <= 1'b1;
                    data_q  <= v1;
                    tmo_q   <= !settled;
                end
            end
            if (state == HOLD && bus.out_ready) begin
                valid_q <= 1'b0;
                arr_q   <= '0;
            end
            if (state == RELEASE && tmo_hit && !settled)
                tmo_q <= 1'b1;
        end
    end

    assign bus.in_ready  = !reset && state == IDLE && clean;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_err   = err_q;
    assign bus.out_tmo   = tmo_q;
    assign bus.arr_uin   = arr_q;
endmodule

// File: tb/tb_ycio_bridge.sv
// tb_ycio_bridge: directed + random words against a 3-cycle echo array model.
// Define RCIO_TIMEOUT_EN to exercise the timeout path with TMO_CYCLES=16.
module tb_ycio_bridge;
    localparam int W      = 8;
    localparam int SETTLE = 2;
`ifdef RCIO_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1023;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int checks  = 0;
    int errors  = 0;
    logic err_exp = 1'b0;

    ycio_if #(.WIDTH(W)) bus ();

    ycio_bridge #(
        .WIDTH(W),
        .SETTLE(SETTLE),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // array: echo after three clocks, with fault hooks
    logic [2*W-1:0] dl [3];
    logic [2*W-1:0] echo;
    logic [2*W-1:0] ovr_val = '0;
    logic force3 = 1'b0;
    logic stuck  = 1'b0;
    logic ovr    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            dl[0] <= '0;
            dl[1] <= '0;
            dl[2] <= '0;
        end else begin
            dl[0] <= bus.arr_uin;
            dl[1] <= dl[0];
            dl[2] <= dl[1];
        end
    end

    always_comb begin
        echo = dl[2];
        if (force3 && echo[7:6] != 2'b00)
            echo[7:6] = 2'b11;
        if (stuck)
            echo = '0;
        bus.arr_uout = ovr ? ovr_val : echo;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] d,
                                           input logic [W-1:0] drv);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            if (drv[i])
                r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_word(input string tag, input logic [W-1:0] d,
                               input logic [W-1:0] drv,
                               input logic [W-1:0] msk);
        int wt;
        bus.in_data  = d;
        bus.in_drv   = drv;
        bus.res_mask = msk;
        bus.in_valid = 1'b1;
        wt = 0;
        while (!bus.in_ready && wt < 60) begin
            step();
            wt++;
        end
        chk({tag, "_ready"}, 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_word(input string tag, input logic [W-1:0] d,
                            input logic [W-1:0] drv,
                            input logic [W-1:0] msk, input int hold);
        int lat;
        int exp_lat;
        logic [W-1:0] exp_d;
        exp_d = d & drv & msk;
        if (force3) begin
            exp_d[3] = 1'b0;
            if (msk[3])
                err_exp = 1'b1;
        end
        exp_lat = (msk == '0) ? SETTLE : 1 + 3 + 2 + SETTLE;
        accept_word(tag, d, drv, msk);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
        chk({tag, "_err"}, 32'(bus.out_err), 32'(err_exp));
        chk({tag, "_tmo"}, 32'(bus.out_tmo), 0);
        for (int k = 0; k < hold; k++) begin
            step();
            chk({tag, "_hv"}, 32'(bus.out_valid), 1);
            chk({tag, "_hd"}, 32'(bus.out_data), 32'(exp_d));
            chk({tag, "_huin"}, 32'(bus.arr_uin), 32'(enc(d, drv)));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_rel_v"}, 32'(bus.out_valid), 0);
        chk({tag, "_rel_uin"}, 32'(bus.arr_uin), 0);
    endtask

    initial begin
        int lat;
        int wt;
        logic [W-1:0] rd;
        logic [W-1:0] rv;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_drv    = '0;
        bus.res_mask  = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_uin", 32'(bus.arr_uin), 0);
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_err", 32'(bus.out_err), 0);
        chk("rst_tmo", 32'(bus.out_tmo), 0);
        reset = 1'b0;
        step();
        chk("idle_ready", 32'(bus.in_ready), 1);

        run_word("a5", 8'hA5, 8'hFF, 8'hFF, 0);
        run_word("hold10", 8'h3C, 8'hFF, 8'hFF, 10);
        run_word("empty", 8'h5A, 8'h00, 8'h00, 1);

        force3 = 1'b1;
        run_word("ill", 8'hA5, 8'hFF, 8'hFF, 1);
        force3 = 1'b0;
        run_word("after_ill", 8'h96, 8'hF0, 8'hF0, 2);

        repeat (20) begin
            rd = 8'($urandom);
            rv = 8'($urandom);
            run_word("rnd", rd, rv, rv, int'($urandom_range(0, 3)));
        end

        reset = 1'b1;
        step();
        err_exp = 1'b0;
        chk("rst_clr_err", 32'(bus.out_err), 0);
        reset = 1'b0;
        step();

        accept_word("drv_rst", 8'hC3, 8'hFF, 8'hFF);
        repeat (2) step();
        chk("drv_rst_uin", 32'(bus.arr_uin), 32'(enc(8'hC3, 8'hFF)));
        reset = 1'b1;
        step();
        chk("drv_rst_uin0", 32'(bus.arr_uin), 0);
        chk("drv_rst_v0", 32'(bus.out_valid), 0);
        chk("drv_rst_rdy0", 32'(bus.in_ready), 0);
        step();
        reset = 1'b0;
        step();
        run_word("post_rst", 8'h69, 8'hFF, 8'hFF, 1);

        // lane 0 returns 01, drops to 00, returns 01 after edge 2
        ovr = 1'b1;
        ovr_val = '0;
        accept_word("glitch", 8'h00, 8'h01, 8'h01);
        ovr_val = 16'h0001;
        step();
        ovr_val = 16'h0000;
        step();
        ovr_val = 16'h0001;
        lat = 2;
        while (!bus.out_valid && lat < 60) begin
            step();
            lat++;
        end
        chk("glitch_lat", lat, 2 + 2 + SETTLE);
        chk("glitch_data", 32'(bus.out_data), 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        ovr_val = '0;
        repeat (4) step();
        ovr = 1'b0;

        stuck = 1'b1;
        accept_word("stuck", 8'hFF, 8'hFF, 8'hFF);
        lat = 0;
`ifdef RCIO_TIMEOUT_EN
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("tmo_lat", lat, TMO);
        chk("tmo_flag", 32'(bus.out_tmo), 1);
        chk("tmo_data", 32'(bus.out_data), 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        wt = 0;
        while (!bus.in_ready && wt < 60) begin
            step();
            wt++;
        end
        chk("tmo_idle", 32'(bus.in_ready), 1);
        chk("tmo_keep", 32'(bus.out_tmo), 1);
`else
        wt = 0;
        while (!bus.out_valid && lat < 1000) begin
            step();
            lat++;
        end
        chk("stuck_valid", 32'(bus.out_valid), 0);
        chk("stuck_tmo", 32'(bus.out_tmo), 0);
        chk("stuck_ready", 32'(bus.in_ready), 32'(wt));
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`endif
        stuck = 1'b0;
        run_word("final", 8'h5A, 8'hFF, 8'hFF, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
